lab72_key_event_ctrl: RTL

//  Avalon-MM slave that debounces the KEY push-buttons, latches press events and raises an IRQ.

---
 rtl/lab72_key_pkg.sv | 22 ++
 rtl/key_debounce.sv | 64 ++++++
 rtl/lab72_key_event_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/lab72_key_pkg.sv
// Shared constants and types for the KEY event controller: register map,
// press-counter width, debounce state encoding and the saturating increment.
package lab72_key_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
  localparam logic [1:0] ADDR_PRESSCNT = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  localparam int PRESSCNT_W = 8;

  typedef enum logic {
    DB_IDLE    = 1'b0,
    DB_PENDING = 1'b1
  } db_state_t;

  // Counts stick at all-ones instead of wrapping.
  function automatic logic [PRESSCNT_W-1:0] sat_inc(input logic [PRESSCNT_W-1:0] v);
    return (&v) ? v : v + PRESSCNT_W'(1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, IDLE/PENDING debounce FSM and a one-cycle
// press pulse emitted when the debounced level commits from released to pressed.
module key_debounce
  import lab72_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  db_state_t        state_reg;
  logic             s;

  assign s = sync_reg[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg  <= 2'b11;
      cnt_reg   <= '0;
      state_reg <= DB_IDLE;
      level     <= 1'b1;
      press     <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], pin};
      press    <= 1'b0;
      case (state_reg)
        DB_IDLE: begin
          // The mismatching sample that opens PENDING is the first of the run.
          if (s != level) begin
            state_reg <= DB_PENDING;
            cnt_reg   <= CNT_W'(1);
          end
        end
        DB_PENDING: begin
          if (s == level) begin
            state_reg <= DB_IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            level     <= s;
            press     <= ~s;
            cnt_reg   <= '0;
            state_reg <= DB_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= DB_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lab72_key_event_ctrl.sv
// Avalon-MM KEY controller: per-key debouncers feed a register file holding
// sticky press flags, an IRQ mask and saturating press counters.
module lab72_key_event_ctrl
  import lab72_key_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [N_KEYS-1:0] in_port,
  output logic              irq
);

  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;

  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .pin    (in_port[gi]),
        .level  (level[gi]),
        .press  (press[gi])
      );
    end
  endgenerate

  logic wr_en, wr_irqmask, wr_presscnt, wr_edgecap;
  assign wr_en       = chipselect && !write_n;
  assign wr_irqmask  = wr_en && (address == ADDR_IRQMASK);
  assign wr_presscnt = wr_en && (address == ADDR_PRESSCNT);
  assign wr_edgecap  = wr_en && (address == ADDR_EDGECAP);

  logic [N_KEYS-1:0]     edgecap_reg, edgecap_next;
  logic [N_KEYS-1:0]     irqmask_reg, irqmask_next;
  logic [PRESSCNT_W-1:0] cnt_reg  [N_KEYS];
  logic [PRESSCNT_W-1:0] cnt_next [N_KEYS];
  logic [31:0]           rd_mux;

  // Press beats a same-cycle W1C; a counter clear is applied before the new press.
  always_comb begin
    edgecap_next = (edgecap_reg & ~(wr_edgecap ? writedata[N_KEYS-1:0] : '0)) | press;
    irqmask_next = wr_irqmask ? writedata[N_KEYS-1:0] : irqmask_reg;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_next[i] = wr_presscnt ? '0 : cnt_reg[i];
      if (press[i]) cnt_next[i] = sat_inc(cnt_next[i]);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux[N_KEYS-1:0] = ~level;
      ADDR_IRQMASK:  rd_mux[N_KEYS-1:0] = irqmask_reg;
      ADDR_PRESSCNT: begin
        for (int i = 0; i < N_KEYS; i++) rd_mux[i*PRESSCNT_W +: PRESSCNT_W] = cnt_reg[i];
      end
      ADDR_EDGECAP:  rd_mux[N_KEYS-1:0] = edgecap_reg;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata    <= '0;
      irq         <= 1'b0;
      edgecap_reg <= '0;
      irqmask_reg <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt_reg[i] <= '0;
    end else begin
      readdata    <= rd_mux;
      edgecap_reg <= edgecap_next;
      irqmask_reg <= irqmask_next;
      irq         <= |(edgecap_next & irqmask_next);
      for (int i = 0; i < N_KEYS; i++) cnt_reg[i] <= cnt_next[i];
    end
  end

endmodule
